// File: rtl/f5_sweep_ctrl.sv
// Sweep sequencer for two f5 (s = ~a & b) implementations: drives every minterm,
// captures both outputs into truth tables and flags disagreement or golden mismatch.
module f5_sweep_ctrl #(
  parameter int                    N_IN       = 2,
  parameter int                    SETTLE_CYC = 1,
  parameter logic [2**N_IN-1:0]    EXPECTED   = 4'b0010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec,
  input  logic                 s_a,
  input  logic                 s_b,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_a,
  output logic [2**N_IN-1:0]   table_b,
  output logic [N_IN:0]        err_count,
  output logic                 mismatch,
  output logic                 exp_err
);

  localparam int CW      = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int SC_LOAD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   settle_cnt;
  logic            flags_vld;
  logic            last_vec;

  assign last_vec = (vec == N_IN'(2**N_IN - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Abort wins over every in-sweep transition, including the final SAMPLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = abort ? IDLE : ((SETTLE_CYC == 0) ? SAMPLE : SETTLE);
      SETTLE:  if (abort) state_nxt = IDLE;
               else if (settle_cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = abort ? IDLE : (last_vec ? DONE : DRIVE);
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec        <= '0;
      table_a    <= '0;
      table_b    <= '0;
      err_count  <= '0;
      flags_vld  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          vec       <= '0;
          table_a   <= '0;
          table_b   <= '0;
          err_count <= '0;
          flags_vld <= 1'b0;
        end
        DRIVE:  settle_cnt <= CW'(SC_LOAD);
        SETTLE: settle_cnt <= settle_cnt - CW'(1);
        SAMPLE: if (!abort) begin
          table_a[vec] <= s_a;
          table_b[vec] <= s_b;
          if (s_a != s_b) err_count <= err_count + (N_IN+1)'(1);
          if (last_vec) flags_vld <= 1'b1;
          else          vec       <= vec + N_IN'(1);
        end
        DONE:    vec <= '0;
        default: ;
      endcase
      if (abort && busy) vec <= '0;
    end
  end

  // Flags are qualified so they read 0 during a sweep and after an abort.
  always_comb begin
    busy     = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    done     = (state == DONE);
    mismatch = flags_vld && (table_a != table_b);
    exp_err  = flags_vld && (table_a != EXPECTED);
  end

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Bench for f5_sweep_ctrl: three instances (SETTLE_CYC 1, 0, 3) swept in lockstep
// against truth tables fed from a reference table model.
module tb_f5_sweep_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] fa = 4'b0010, fb = 4'b0010;
  logic [1:0] vec_w  [3];
  logic       s_a_w  [3], s_b_w [3], busy_w [3], done_w [3], mm_w [3], ee_w [3];
  logic [3:0] ta_w   [3], tb_w  [3];
  logic [2:0] ec_w   [3];
  int n_cmp = 0, n_bad = 0;

  localparam logic [3:0] GOLD = 4'b0010;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    f5_sweep_ctrl #(.N_IN(2), .SETTLE_CYC((g == 0) ? 1 : ((g == 1) ? 0 : 3)), .EXPECTED(4'b0010)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .vec(vec_w[g]),
      .s_a(s_a_w[g]), .s_b(s_b_w[g]), .busy(busy_w[g]), .done(done_w[g]),
      .table_a(ta_w[g]), .table_b(tb_w[g]), .err_count(ec_w[g]),
      .mismatch(mm_w[g]), .exp_err(ee_w[g]));
    // The "f5 instances" are table lookups, so faults are just different tables.
    assign s_a_w[g] = fa[vec_w[g]];
    assign s_b_w[g] = fb[vec_w[g]];
  end

  function automatic int st(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if ({vec_w[g], busy_w[g], done_w[g], ta_w[g], tb_w[g], ec_w[g], mm_w[g], ee_w[g]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state inst%0d: vec=%0d busy=%b done=%b ta=%b tb=%b ec=%0d mm=%b ee=%b, want all 0",
                 g, vec_w[g], busy_w[g], done_w[g], ta_w[g], tb_w[g], ec_w[g], mm_w[g], ee_w[g]);
      end
    end
    reset = 1'b0;
  endtask

  // Full sweep; expected timeline: minterm m held SETTLE_CYC+2 cycles, done the cycle after.
  task automatic test_sweep(input logic [3:0] a_tab, input logic [3:0] b_tab,
                            input bit rep, input bit with_abort, input string nm);
    int  dcnt [3];
    bit  trace_ok [3];
    int  len;
    logic [2:0] ec_exp;
    fa = a_tab; fb = b_tab;
    ec_exp = 3'($countones(a_tab ^ b_tab));
    @(negedge clk); start = 1'b1; abort = with_abort;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int g = 0; g < 3; g++) begin dcnt[g] = 0; trace_ok[g] = 1'b1; end
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        len = 4 * (st(g) + 2);
        if (done_w[g] === 1'b1) dcnt[g]++;
        if (c <= len) begin
          if (busy_w[g] !== 1'b1 || done_w[g] !== 1'b0 || vec_w[g] !== 2'((c - 1) / (st(g) + 2)))
            trace_ok[g] = 1'b0;
        end else if (c == len + 1) begin
          if (done_w[g] !== 1'b1 || busy_w[g] !== 1'b0) trace_ok[g] = 1'b0;
          n_cmp += 5;
          if (ta_w[g] !== a_tab) begin n_bad++;
            $display("FAIL %s table_a inst%0d: got %b want %b", nm, g, ta_w[g], a_tab); end
          if (tb_w[g] !== b_tab) begin n_bad++;
            $display("FAIL %s table_b inst%0d: got %b want %b", nm, g, tb_w[g], b_tab); end
          if (ec_w[g] !== ec_exp) begin n_bad++;
            $display("FAIL %s err_count inst%0d: got %0d want %0d", nm, g, ec_w[g], ec_exp); end
          if (mm_w[g] !== (a_tab != b_tab)) begin n_bad++;
            $display("FAIL %s mismatch inst%0d: got %b want %b", nm, g, mm_w[g], a_tab != b_tab); end
          if (ee_w[g] !== (a_tab != GOLD)) begin n_bad++;
            $display("FAIL %s exp_err inst%0d: got %b want %b", nm, g, ee_w[g], a_tab != GOLD); end
        end else if (busy_w[g] !== 1'b0 || done_w[g] !== 1'b0 || vec_w[g] !== 2'd0) begin
          trace_ok[g] = 1'b0;
        end
      end
      start = (rep && c <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    for (int g = 0; g < 3; g++) begin
      n_cmp += 3;
      if (!trace_ok[g]) begin n_bad++;
        $display("FAIL %s timeline inst%0d: vec/busy/done sequence off, want %0d cycles per minterm", nm, g, st(g) + 2); end
      if (dcnt[g] != 1) begin n_bad++;
        $display("FAIL %s done_pulses inst%0d: got %0d want 1", nm, g, dcnt[g]); end
      if (ta_w[g] !== a_tab || ec_w[g] !== ec_exp) begin n_bad++;
        $display("FAIL %s hold inst%0d: ta=%b ec=%0d want %b %0d", nm, g, ta_w[g], ec_w[g], a_tab, ec_exp); end
    end
  endtask

  task automatic test_abort();
    logic [3:0] b_tab;
    int dcnt;
    b_tab = 4'($urandom);
    fa = GOLD; fb = b_tab;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);  // cycle 8: inst0 holds vec=2 in SETTLE
    n_cmp++;
    if (vec_w[0] !== 2'd2 || busy_w[0] !== 1'b1) begin n_bad++;
      $display("FAIL abort_setup: vec=%0d busy=%b want 2 1", vec_w[0], busy_w[0]); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (busy_w[g] !== 1'b0 || done_w[g] !== 1'b0 || vec_w[g] !== 2'd0 || mm_w[g] !== 1'b0 || ee_w[g] !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_idle inst%0d: busy=%b done=%b vec=%0d mm=%b ee=%b want 0", g,
                 busy_w[g], done_w[g], vec_w[g], mm_w[g], ee_w[g]);
      end
    end
    n_cmp++;
    if (ta_w[0] !== 4'b0010 || tb_w[0] !== (b_tab & 4'b0011) ||
        ec_w[0] !== 3'($countones((GOLD ^ b_tab) & 4'b0011))) begin
      n_bad++;
      $display("FAIL abort_partial: ta=%b tb=%b ec=%0d want %b %b %0d", ta_w[0], tb_w[0], ec_w[0],
               4'b0010, b_tab & 4'b0011, $countones((GOLD ^ b_tab) & 4'b0011));
    end
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (done_w[g] !== 1'b0 || busy_w[g] !== 1'b0) dcnt++;
    end
    n_cmp++;
    if (dcnt != 0) begin n_bad++;
      $display("FAIL abort_quiet: %0d cycles with done/busy high, want 0", dcnt); end
  endtask

  task automatic test_reset_mid();
    fa = 4'b1111; fb = 4'b0000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);  // cycle 5: inst0 at vec=1, vec 0 already captured
    n_cmp++;
    if (vec_w[0] !== 2'd1 || ec_w[0] !== 3'd1) begin n_bad++;
      $display("FAIL reset_mid_setup: vec=%0d ec=%0d want 1 1", vec_w[0], ec_w[0]); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if ({vec_w[g], busy_w[g], done_w[g], ta_w[g], tb_w[g], ec_w[g], mm_w[g], ee_w[g]} !== '0) begin
        n_bad++;
        $display("FAIL reset_mid inst%0d: vec=%0d busy=%b ta=%b tb=%b ec=%0d want all 0",
                 g, vec_w[g], busy_w[g], ta_w[g], tb_w[g], ec_w[g]);
      end
    end
    repeat (22) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (done_w[g] !== 1'b0 || busy_w[g] !== 1'b0) begin n_bad++;
        $display("FAIL reset_mid_quiet inst%0d: busy=%b done=%b want 0 0", g, busy_w[g], done_w[g]); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep(GOLD, GOLD, 1'b0, 1'b0, "clean");
    test_sweep(GOLD, 4'b1111, 1'b0, 1'b0, "sb_stuck1");
    test_sweep(4'b1011, 4'b1011, 1'b0, 1'b0, "both_or");
    test_abort();
    test_sweep(GOLD, GOLD, 1'b0, 1'b0, "after_abort");
    test_sweep(GOLD, 4'($urandom), 1'b1, 1'b0, "repeat_start");
    test_sweep(4'($urandom), GOLD, 1'b0, 1'b1, "start_abort_same");
    test_reset_mid();
    for (int i = 0; i < 6; i++)
      test_sweep(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
